// File: rtl/maple_pkg.sv
// Maple bus transmitter shared definitions.
// State encoding, phase lengths and fixed line patterns.
package maple_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    PRE,
    START,
    DATA,
    END,
    POST
  } state_e;

  localparam logic [3:0] START_STEPS   = 4'd10;
  localparam logic [3:0] END_STEPS     = 4'd6;
  localparam logic [1:0] STEPS_PER_BIT = 2'd3;

  // {A,B} for START step s: A low, four B pulses, A high
  function automatic logic [1:0] start_ab(input logic [3:0] s);
    logic [1:0] ab;
    ab = {1'b0, ~s[0]};
    if (s == 4'd0) ab = 2'b01;
    if (s == START_STEPS - 4'd1) ab = 2'b11;
    return ab;
  endfunction

  // {A,B} for END step s: B low, two A pulses, B high
  function automatic logic [1:0] end_ab(input logic [3:0] s);
    logic [1:0] ab;
    ab = {~s[0], 1'b0};
    if (s == END_STEPS - 4'd1) ab = 2'b11;
    return ab;
  endfunction

endpackage

// File: rtl/maple_tick.sv
// Bus step strobe generator.
// Counter is held at zero whenever stepping is disabled.
module maple_tick
  import maple_pkg::*;
#(
  parameter int TICK_CYCLES = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic tick_o
);

  localparam int W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_CYCLES - 1);

  logic [W-1:0] cnt_q;

  assign tick_o = en_i && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (!en_i || tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/maple_tx.sv
// Maple bus frame transmitter.
// Pulls payload bytes from a FIFO and drives the A/B bus lines.
module maple_tx
  import maple_pkg::*;
#(
  parameter int TICK_CYCLES = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] byte_count,
  input  logic [7:0] fifo_data,
  input  logic       fifo_avail,
  input  logic [7:0] fifo_avail_cnt,
  output logic       fifo_strobe,
  output logic       sdcka,
  output logic       sdckb,
  output logic       drive_en,
  output logic       busy,
  output logic       done
);

  state_e     state_q;
  logic [7:0] cnt_q;
  logic [7:0] sh_q;
  logic [3:0] step_q;
  logic [2:0] bit_q;
  logic [1:0] sub_q;
  logic       a_q;
  logic       b_q;
  logic       de_q;
  logic       strobe_q;
  logic       busy_q;
  logic       done_q;
  logic       tick;
  logic       tick_en;
  logic       start_last;
  logic       bit_last;

  assign tick_en = !(state_q == IDLE || state_q == WAIT_DATA);

  maple_tick #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .en_i  (tick_en),
    .tick_o(tick)
  );

  assign start_last = (state_q == START) &&
                      (step_q == START_STEPS - 4'd1);
  assign bit_last   = (state_q == DATA) && (bit_q == 3'd0) &&
                      (sub_q == STEPS_PER_BIT - 2'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sh_q     <= '0;
      step_q   <= '0;
      bit_q    <= '0;
      sub_q    <= '0;
      a_q      <= 1'b1;
      b_q      <= 1'b1;
      de_q     <= 1'b0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      // byte boundary: either the payload ends or the next head byte loads
      if (tick && (start_last || bit_last)) begin
        if (cnt_q == 8'd0) begin
          state_q      <= END;
          step_q       <= '0;
          {a_q, b_q}   <= end_ab(4'd0);
        end else begin
          state_q  <= DATA;
          sh_q     <= fifo_data;
          bit_q    <= 3'd7;
          sub_q    <= '0;
          b_q      <= fifo_data[7];
          strobe_q <= fifo_avail;
          cnt_q    <= cnt_q - 8'd1;
        end
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start && !done_q) begin
              cnt_q   <= byte_count;
              busy_q  <= 1'b1;
              state_q <= WAIT_DATA;
            end
          end
          WAIT_DATA: begin
            if (fifo_avail_cnt >= cnt_q) begin
              state_q <= PRE;
              de_q    <= 1'b1;
              a_q     <= 1'b1;
              b_q     <= 1'b1;
            end
          end
          PRE: begin
            if (tick) begin
              state_q    <= START;
              step_q     <= '0;
              {a_q, b_q} <= start_ab(4'd0);
            end
          end
          START: begin
            if (tick) begin
              step_q     <= step_q + 4'd1;
              {a_q, b_q} <= start_ab(step_q + 4'd1);
            end
          end
          DATA: begin
            if (tick) begin
              if (sub_q == STEPS_PER_BIT - 2'd1) begin
                // odd positions clock on A, so the next bit's data is on A
                bit_q <= bit_q - 3'd1;
                sub_q <= '0;
                if (bit_q[0]) a_q <= sh_q[bit_q - 3'd1];
                else          b_q <= sh_q[bit_q - 3'd1];
              end else begin
                sub_q <= sub_q + 2'd1;
                if (sub_q == 2'd0) begin
                  if (bit_q[0]) a_q <= 1'b0;
                  else          b_q <= 1'b0;
                end else begin
                  if (bit_q[0]) b_q <= 1'b1;
                  else          a_q <= 1'b1;
                end
              end
            end
          end
          END: begin
            if (tick) begin
              if (step_q == END_STEPS - 4'd1) begin
                state_q <= POST;
                a_q     <= 1'b1;
                b_q     <= 1'b1;
              end else begin
                step_q     <= step_q + 4'd1;
                {a_q, b_q} <= end_ab(step_q + 4'd1);
              end
            end
          end
          POST: begin
            if (tick) begin
              state_q <= IDLE;
              de_q    <= 1'b0;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign fifo_strobe = strobe_q;
  assign sdcka       = a_q;
  assign sdckb       = b_q;
  assign drive_en    = de_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: doc/maple_tx.md
MAPLE_TX -- requirements
Module: maple_tx

Interface
REQ-001 SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-002 Parameter: TICK_CYCLES, default 25, clk cycles per bus step (500 ns at 50 MHz).
REQ-003 Port: clk  input  1  system clock, all logic on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset.
REQ-005 Port: start  input  1  one-cycle request to transmit a frame; sampled only in IDLE.
REQ-006 Port: byte_count  input  8  frame payload length in bytes, 0..255; latched with start.
REQ-007 Port: fifo_data  input  8  FIFO head byte, valid combinationally while fifo_avail=1.
REQ-008 Port: fifo_avail  input  1  FIFO non-empty.
REQ-009 Port: fifo_avail_cnt  input  8  bytes currently held in FIFO.
REQ-010 Port: fifo_strobe  output  1  one-cycle pop of FIFO head.
REQ-011 Port: sdcka  output  1  Maple line A drive value.
REQ-012 Port: sdckb  output  1  Maple line B drive value.
REQ-013 Port: drive_en  output  1  pad output enable for both lines.
REQ-014 Port: busy  output  1  frame request in progress.
REQ-015 Port: done  output  1  one-cycle pulse at frame completion.

Function
REQ-016 States SHALL be IDLE, WAIT_DATA, PRE, START, DATA, END, POST.
REQ-017 IDLE: start=1 latches byte_count; busy=1 next cycle; enters WAIT_DATA; start ignored in every other state.
REQ-018 WAIT_DATA: leaves for PRE when fifo_avail_cnt >= latched count (count 0 leaves immediately); no timeout.
REQ-019 One step = TICK_CYCLES clk cycles; sdcka/sdckb/drive_en SHALL be registered and change only at step boundaries.
REQ-020 PRE, 1 step: drive_en=1, A=1, B=1.
REQ-021 START, 10 steps: A=0; then B=0,1 repeated 4 times; then A=1.
REQ-022 DATA: bytes MSB first; each bit takes 3 steps: data line := bit, clock line := 0, data line := 1.
REQ-023 Bit positions 7,5,3,1 use clock A / data B; positions 6,4,2,0 use clock B / data A.
REQ-024 At the first step of each byte, fifo_data SHALL be loaded into a shift register and fifo_strobe pulsed for exactly one cycle; 24 steps per byte.
REQ-025 END, 6 steps: B=0, A=0, A=1, A=0, A=1, B=1.
REQ-026 POST, 1 step: A=1, B=1, then drive_en=0; done=1 and busy=0 in the same cycle; returns to IDLE.
REQ-027 Total frame length SHALL be (18 + 24*N) steps from PRE through POST, for N payload bytes.
REQ-028 fifo_strobe SHALL never be asserted while fifo_avail=0 and SHALL be asserted exactly N times per frame.
REQ-029 start in the same cycle as done SHALL be ignored; a new frame requires start while in IDLE.

Reset
REQ-030 While rst=0: state=IDLE, sdcka=1, sdckb=1, drive_en=0, fifo_strobe=0, busy=0, done=0, all counters 0; takes effect immediately, including mid-frame.
REQ-031 Reset mid-frame SHALL NOT pop further bytes; already-popped bytes are lost.

Structure
REQ-032 Package maple_pkg SHALL hold the state encoding, START_STEPS=10, END_STEPS=6, STEPS_PER_BIT=3.
REQ-033 Sub-module maple_tick SHALL generate the one-cycle step strobe from TICK_CYCLES and hold its counter at 0 in IDLE and WAIT_DATA.

Verification
REQ-034 TICK_CYCLES=2, FIFO preloaded with 0xA5, start with byte_count=1 -> A/B trace matches REQ-020..026, decoded byte 0xA5, 42 steps, one fifo_strobe, one done.
REQ-035 byte_count=0 -> PRE, START, END, POST only, 18 steps, zero fifo_strobe.
REQ-036 byte_count=4, FIFO holds 2 bytes, third byte pushed after 100 cycles, fourth after 200 cycles -> stays in WAIT_DATA with drive_en=0 until fifo_avail_cnt=4, then sends all 4 bytes in order.
REQ-037 rst=0 during byte 2 of a 3-byte frame -> outputs idle same cycle, exactly 2 strobes total, and next frame correct.
REQ-038 start pulsed while busy and again coincident with done -> both ignored; exactly one frame observed.
REQ-039 byte_count=255 with 0x00..0xFE streamed -> 255 strobes, all bytes decoded correctly by reference Maple receiver model.
